out_uart_tx: RTL and testbench

Serial output stage for the stack CPU's `OUT` instruction. Captures each byte the CPU presents on `LEDS`, qualified by a rising edge of `Lr`, into a small FIFO. Transmits the bytes LSB-first as 8N1 asynchronous serial frames on `tx`. Sits directly downstream of the CPU, so program output can be logged off-chip without stalling the core.

---
 rtl/out_uart_pkg.sv | 15 +
 rtl/out_uart_tx_fifo.sv | 56 +++++
 rtl/out_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_out_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/out_uart_pkg.sv
// Shared types and constants for the OUT-instruction serial output stage.
package out_uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/out_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit.
module out_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/out_uart_tx.sv
// Captures CPU OUT bytes on a rising Lr edge and sends them as 8N1 serial frames.
// Define OUT_UART_PARITY_EN for 8E1 frames (even parity bit between data and stop).
module out_uart_tx
  import out_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    LEDS,
  input  logic                          Lr,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [3:0]    BITS_LAST = 4'(UART_DATA_BITS - 1);

  tx_state_t   state_q;
  logic [BW-1:0] baud_q;
  logic [3:0]  bit_q;
  logic [7:0]  shreg_q;
  logic        tx_q;
  logic        lr_q;
  logic        overflow_q;
`ifdef OUT_UART_PARITY_EN
  logic        parity_q;
`endif

  logic        capture, pop, baud_last;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;

  assign capture   = Lr & ~lr_q;
  assign baud_last = (baud_q == BAUD_LAST);
  // The last stop cycle may pop so the next start bit follows with no gap.
  assign pop       = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & baud_last));

  out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (LEDS),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lr_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      lr_q <= Lr;
      if (capture & fifo_full & ~pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= UART_IDLE_LEVEL;
`ifdef OUT_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= UART_IDLE_LEVEL;
          if (!fifo_empty) begin
            shreg_q  <= fifo_dout;
`ifdef OUT_UART_PARITY_EN
            parity_q <= ^fifo_dout;
`endif
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BITS_LAST) begin
`ifdef OUT_UART_PARITY_EN
              bit_q   <= bit_q + 4'd1;
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= STOP;
`endif
            end else begin
              bit_q   <= bit_q + 4'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`ifdef OUT_UART_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shreg_q  <= fifo_dout;
`ifdef OUT_UART_PARITY_EN
              parity_q <= ^fifo_dout;
`endif
              bit_q    <= '0;
              tx_q     <= 1'b0;
              state_q  <= START;
            end else begin
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          tx_q    <= UART_IDLE_LEVEL;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_out_uart_tx.sv
// Scoreboard bench for out_uart_tx: a serial receiver model checks frames against queued bytes.
module tb_out_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
`ifdef OUT_UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Lr  = 1'b0;
  logic [7:0] LEDS = 8'h00;
  logic       tx, busy, overflow;
  logic [3:0] fifo_count;

  out_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .LEDS       (LEDS),
    .Lr         (Lr),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];   // {expected parity, expected byte}
  int start_q[$];
  int frames = 0;
  logic mon_ab = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon_wait(input int n);
    for (int k = 0; k < n && !mon_ab; k++) begin
      @(negedge clk);
      if (rst) mon_ab = 1'b1;
    end
  endtask

  // Receiver model: samples each bit at its midpoint; a reset aborts the frame.
  initial begin : monitor
    logic [7:0] d;
    logic [8:0] e;
    logic       p;
    int         s;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        s = cyc;
        mon_ab = 1'b0;
        p = 1'b0;
        mon_wait(CPB / 2);
        if (!mon_ab) chk("start_bit", int'(tx), 0);
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          d[i] = tx;
        end
`ifdef OUT_UART_PARITY_EN
        mon_wait(CPB);
        p = tx;
`endif
        mon_wait(CPB);
        if (!mon_ab) begin
          chk("stop_bit", int'(tx), 1);
          start_q.push_back(s);
          frames++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h required=none", d);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", int'(d), int'(e[7:0]));
`ifdef OUT_UART_PARITY_EN
            chk("rx_parity", int'(p), int'(e[8]));
`else
            if (p !== 1'b0 && e[8] === 1'bx) $display("note: parity flag unknown");
`endif
          end
        end
      end
    end
  end

  task automatic wait_idle(input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < maxc);
    chk("idle_timeout", int'(busy), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    LEDS = b;
    Lr   = 1'b1;
    @(posedge clk); #1;
    Lr   = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    int f0, s0;
    logic [9:0] par_bits;
    par_bits = 10'b0110010110;   // even parity of 1..9, indexed by value

    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_state", int'({tx, busy, overflow, fifo_count}), int'(7'b1000000));
    end

    // Single byte 0xA5: latency and busy duration
    @(posedge clk); #1;
    LEDS = 8'hA5;
    Lr   = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    @(negedge clk);
    chk("lat_count_n", int'(fifo_count), 0);
    @(negedge clk);
    chk("lat_count_n1", int'(fifo_count), 1);
    chk("lat_tx_n1", int'(tx), 1);
    @(negedge clk);
    chk("lat_tx_n2", int'(tx), 0);
    chk("lat_busy_n2", int'(busy), 1);
    Lr = 1'b0;
    repeat (FRAME - 1) @(negedge clk);
    chk("busy_last_stop", int'(busy), 1);
    chk("tx_last_stop", int'(tx), 1);
    @(negedge clk);
    chk("busy_fall", int'(busy), 0);
    wait_idle(FRAME + 50);

    // Lr held high with LEDS changing: single capture
    f0 = frames;
    @(posedge clk); #1;
    LEDS = 8'h5A;
    Lr   = 1'b1;
    exp_q.push_back({1'b0, 8'h5A});
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      LEDS = LEDS + 8'h13;
    end
    Lr = 1'b0;
    wait_idle(2 * FRAME);
    chk("held_one_frame", frames - f0, 1);

    // Ten edges 4 cycles apart into a depth-8 FIFO
    s0 = start_q.size();
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin
        chk("pre_ovf_flag", int'(overflow), 0);
        chk("pre_ovf_count", int'(fifo_count), 8);
      end
      LEDS = 8'(i);
      Lr   = 1'b1;
      if (i <= 9) exp_q.push_back({par_bits[i], 8'(i)});
      @(posedge clk); #1;
      Lr = 1'b0;
      @(posedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(fifo_count), 8);
    wait_idle(9 * FRAME + 100);
    chk("ovf_sticky", int'(overflow), 1);
    chk("b2b_frames", start_q.size() - s0, 9);
    for (int k = 1; k < 9; k++)
      if (s0 + k < start_q.size())
        chk("b2b_gap", start_q[s0 + k] - start_q[s0 + k - 1], FRAME);

    // Reset 40 cycles into the 0x3C frame with two bytes queued
    @(posedge clk); #1;
    LEDS = 8'h3C;
    Lr   = 1'b1;
    @(posedge clk); #1;
    Lr = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    LEDS = 8'h11;
    Lr   = 1'b1;
    @(posedge clk); #1;
    Lr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    LEDS = 8'h22;
    Lr   = 1'b1;
    @(posedge clk); #1;
    Lr = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    chk("pre_rst_count", int'(fifo_count), 2);
    chk("pre_rst_tx_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    f0 = frames;
    repeat (400) @(negedge clk);
    chk("post_rst_frames", frames - f0, 0);
    chk("post_rst_busy", int'(busy), 0);

    // Parity vectors (plain frames when parity is disabled)
    exp_q.push_back({1'b1, 8'h07});
    send(8'h07);
    wait_idle(2 * FRAME);
    exp_q.push_back({1'b0, 8'h03});
    send(8'h03);
    wait_idle(2 * FRAME);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
